// File: rtl/uart_tx_os_if.sv
// Parallel-side and serial-side signals of the oversampling UART transmitter.
// The master drives the byte request; the slave (the transmitter) drives TX_OUT and Busy.
interface uart_tx_os_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  PAR_TYP;
    logic                  PAR_EN;
    logic [5:0]            Prescale;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  DATA_VALID;
    logic                  TX_OUT;
    logic                  Busy;

    modport master (
        output PAR_TYP, PAR_EN, Prescale, P_DATA, DATA_VALID,
        input  TX_OUT, Busy
    );

    modport slave (
        input  PAR_TYP, PAR_EN, Prescale, P_DATA, DATA_VALID,
        output TX_OUT, Busy
    );
endinterface

// File: rtl/uart_tx_os.sv
// UART transmitter timed by Prescale cycles of the shared oversampling clock.
// Define UART_TX_TWO_STOP_EN to send two stop bits instead of one.
module uart_tx_os #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input logic         CLK,
    input logic         RST,
    uart_tx_os_if.slave bus
);
    localparam int unsigned BitW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StStart  = 3'd1;
    localparam logic [2:0] StData   = 3'd2;
    localparam logic [2:0] StParity = 3'd3;
    localparam logic [2:0] StStop   = 3'd4;

    logic [2:0]            state_q, state_d;
    logic [5:0]            cnt_q, cnt_d;
    logic [BitW-1:0]       bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [5:0]            presc_q, presc_d;
    logic                  par_en_q, par_en_d;
    logic                  par_bit_q, par_bit_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  bit_end;
`ifdef UART_TX_TWO_STOP_EN
    logic                  stop2_q, stop2_d;
`endif

    assign bit_end = (cnt_q == presc_q - 6'd1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        presc_d   = presc_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
`ifdef UART_TX_TWO_STOP_EN
        stop2_d   = stop2_q;
`endif
        if (state_q == StIdle) begin
            if (bus.DATA_VALID) begin
                state_d   = StStart;
                presc_d   = (bus.Prescale == 6'd0) ? 6'd1 : bus.Prescale;
                shift_d   = bus.P_DATA;
                par_en_d  = bus.PAR_EN;
                par_bit_d = (^bus.P_DATA) ^ bus.PAR_TYP;
                cnt_d     = 6'd0;
                bit_d     = '0;
                tx_d      = 1'b0;
                busy_d    = 1'b1;
            end
        end else if (!bit_end) begin
            cnt_d = cnt_q + 6'd1;
        end else begin
            cnt_d = 6'd0;
            case (state_q)
                StStart: begin
                    state_d = StData;
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                end
                StData: begin
                    if (bit_q == BitW'(DATA_WIDTH - 1)) begin
                        bit_d = '0;
                        if (par_en_q) begin
                            state_d = StParity;
                            tx_d    = par_bit_q;
                        end else begin
                            state_d = StStop;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d   = bit_q + BitW'(1);
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                    end
                end
                StParity: begin
                    state_d = StStop;
                    tx_d    = 1'b1;
                end
                StStop: begin
`ifdef UART_TX_TWO_STOP_EN
                    if (!stop2_q) begin
                        stop2_d = 1'b1;
                    end else begin
                        stop2_d = 1'b0;
                        state_d = StIdle;
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                    end
`else
                    state_d = StIdle;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
`endif
                end
                default: begin
                    state_d = StIdle;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= StIdle;
            cnt_q     <= 6'd0;
            bit_q     <= '0;
            shift_q   <= '0;
            presc_q   <= 6'd1;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
            stop2_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            presc_q   <= presc_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
`ifdef UART_TX_TWO_STOP_EN
            stop2_q   <= stop2_d;
`endif
        end
    end

    // Outputs come straight from flops so the serial line never glitches.
    assign bus.TX_OUT = tx_q;
    assign bus.Busy   = busy_q;
endmodule

// File: tb/tb_uart_tx_os.sv
// Scoreboard bench for uart_tx_os: stimulus queues expected frames, a monitor
// reconstructs each serial frame at negedges and compares it with a reference model.
module tb_uart_tx_os;
    logic clk;
    logic rst;

    uart_tx_os_if #(.DATA_WIDTH(8)) bus ();

    uart_tx_os #(.DATA_WIDTH(8)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       pe;
        logic       pt;
        logic [6:0] p;
    } frame_t;

    frame_t exp_q[$];
    int     tests = 0;
    int     fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: frame laid out as start, data LSB first, optional parity, stop(s).
    function automatic logic exp_bit(input frame_t f, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return f.data[b-1];
        if (f.pe && b == 9) return (^f.data) ^ f.pt;
        return 1'b1;
    endfunction

    function automatic int frame_len(input frame_t f);
        int stops = 1;
`ifdef UART_TX_TWO_STOP_EN
        stops = 2;
`endif
        return (1 + 8 + int'(f.pe) + stops) * int'(f.p);
    endfunction

    // Monitor
    frame_t cur;
    bit     active = 0;
    bit     rogue  = 0;
    bit     bad    = 0;
    int     idx    = 0;
    int     fno    = 0;

    always @(negedge clk) begin
        if (!rst) begin
            active = 0;
            rogue  = 0;
        end else begin
            if (!bus.Busy) rogue = 0;
            if (!active && bus.Busy && !rogue) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", 32'd1, 32'd0);
                    rogue = 1;
                end else begin
                    cur    = exp_q.pop_front();
                    active = 1;
                    idx    = 0;
                    bad    = 0;
                end
            end
            if (active && bus.Busy) begin
                if (bus.TX_OUT !== exp_bit(cur, idx / int'(cur.p))) bad = 1;
                if ((idx % int'(cur.p)) == int'(cur.p) - 1) begin
                    check($sformatf("frame%0d_bit%0d", fno, idx / int'(cur.p)), {31'd0, bad}, 0);
                    bad = 0;
                end
                idx++;
            end else if (active && !bus.Busy) begin
                check($sformatf("frame%0d_busy_len", fno), idx, frame_len(cur));
                check($sformatf("frame%0d_idle_line", fno), {31'd0, bus.TX_OUT}, 1);
                active = 0;
                fno++;
            end
        end
    end

    task automatic wait_idle(input int max);
        int n = 0;
        while (bus.Busy === 1'b1 && n < max) begin
            @(negedge clk);
            n++;
        end
        if (bus.Busy !== 1'b0) check("idle_timeout", {31'd0, bus.Busy}, 0);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pe, input logic pt,
                              input logic [5:0] presc);
        frame_t f;
        @(negedge clk);
        wait_idle(3000);
        bus.P_DATA     = d;
        bus.PAR_EN     = pe;
        bus.PAR_TYP    = pt;
        bus.Prescale   = presc;
        bus.DATA_VALID = 1'b1;
        f.data = d;
        f.pe   = pe;
        f.pt   = pt;
        f.p    = (presc == 6'd0) ? 7'd1 : {1'b0, presc};
        exp_q.push_back(f);
        @(negedge clk);
        bus.DATA_VALID = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        frame_t f;
        int     n;
        int     gap;
        bit     idle_bad;

        rst            = 1'b0;
        bus.P_DATA     = 8'h00;
        bus.PAR_EN     = 1'b0;
        bus.PAR_TYP    = 1'b0;
        bus.Prescale   = 6'd0;
        bus.DATA_VALID = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_tx_out", {31'd0, bus.TX_OUT}, 1);
        check("reset_busy", {31'd0, bus.Busy}, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        send_frame(8'hA5, 1'b1, 1'b0, 6'd8);
        send_frame(8'h01, 1'b1, 1'b1, 6'd16);
        send_frame(8'hFF, 1'b0, 1'b0, 6'd8);
        send_frame(8'h55, 1'b0, 1'b0, 6'd0);

        // DATA_VALID pulse and Prescale change while busy must be ignored.
        send_frame(8'hA5, 1'b1, 1'b0, 6'd8);
        repeat (20) @(negedge clk);
        bus.P_DATA     = 8'h3C;
        bus.Prescale   = 6'd4;
        bus.DATA_VALID = 1'b1;
        @(negedge clk);
        bus.DATA_VALID = 1'b0;
        wait_idle(200);
        repeat (40) @(negedge clk);
        check("no_second_frame", {31'd0, bus.Busy}, 0);

        // DATA_VALID held through frame end: next frame after a one-cycle gap.
        send_frame(8'h5A, 1'b1, 1'b1, 6'd4);
        repeat (3) @(negedge clk);
        bus.P_DATA     = 8'hC3;
        bus.PAR_EN     = 1'b0;
        bus.PAR_TYP    = 1'b0;
        bus.Prescale   = 6'd3;
        bus.DATA_VALID = 1'b1;
        f.data = 8'hC3;
        f.pe   = 1'b0;
        f.pt   = 1'b0;
        f.p    = 7'd3;
        exp_q.push_back(f);
        n = 0;
        while (bus.Busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        gap = 0;
        while (!bus.Busy && gap < 10) begin
            gap++;
            @(negedge clk);
        end
        check("back_to_back_gap", gap, 1);
        bus.DATA_VALID = 1'b0;
        wait_idle(200);

        // Reset asserted during data bit 3 aborts the frame asynchronously.
        send_frame(8'hF0, 1'b1, 1'b0, 6'd8);
        repeat (34) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("async_reset_tx_out", {31'd0, bus.TX_OUT}, 1);
        check("async_reset_busy", {31'd0, bus.Busy}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        idle_bad = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.TX_OUT !== 1'b1 || bus.Busy !== 1'b0) idle_bad = 1;
        end
        check("idle_after_reset", {31'd0, idle_bad}, 0);

        for (int i = 0; i < 12; i++) begin
            send_frame(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 6'($urandom_range(0, 10)));
        end

        wait_idle(3000);
        repeat (5) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        check("monitor_idle", {31'd0, active}, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_tx_os.md
Name: uart_tx_os

Overview:
- UART transmitter that runs on the same oversampling clock as the UART receiver and derives bit timing from Prescale, not from a dedicated baud-rate clock.
- It is the transmit-side counterpart of the oversampling receiver, so both directions of a link can share one clock.
- Serializes one byte per frame: start bit, 8 data bits LSB first, optional parity bit, stop bit.
- Sits beside the receiver in the UART top level; a loopback bench connects TX_OUT to the receiver's serial input.

Parameters:
DATA_WIDTH, 8, number of data bits per frame

Ports:
CLK  input  1  oversampling clock, rising edge
RST  input  1  asynchronous reset, active-low
PAR_TYP  input  1  0 = even parity, 1 = odd parity
PAR_EN  input  1  1 = insert parity bit
Prescale  input  6  clock cycles per bit; 0 is treated as 1
P_DATA  input  DATA_WIDTH  byte to transmit
DATA_VALID  input  1  request; accepted only when Busy=0
TX_OUT  output  1  serial line, registered, idle high
Busy  output  1  high from the first start-bit cycle to the last stop-bit cycle

Behaviour:
- Reset (RST=0, asynchronous):
  - TX_OUT=1, Busy=0, FSM=IDLE; bit counter and cycle counter = 0.
  - Asserting reset mid-frame aborts the frame immediately. After release the block is IDLE and no partial frame resumes.
- Acceptance:
  - At a rising edge with FSM=IDLE and DATA_VALID=1, the block latches P_DATA, PAR_TYP, PAR_EN and Prescale (0 is mapped to 1).
  - It computes the parity bit: even = XOR of the data bits; odd = inverted XOR of the data bits.
  - From that edge onward, TX_OUT=0 (start bit) and Busy=1.
  - Latency from the accepting edge to the start bit on TX_OUT is 0 extra cycles (visible after the accepting edge).
- Inputs while Busy:
  - DATA_VALID is ignored; nothing is queued.
  - Changes on P_DATA, PAR_TYP, PAR_EN and Prescale do not affect the frame in flight.
- FSM states: IDLE -> START -> DATA -> (PARITY if PAR_EN latched) -> STOP -> IDLE.
  - Each state holds TX_OUT constant for exactly P cycles, where P is the latched Prescale.
  - DATA repeats for DATA_WIDTH bits, bit index 0 first; the bit counter wraps to 0 on leaving DATA.
- Counters:
  - 6-bit cycle counter runs 0..P-1 and reloads 0 on each bit boundary.
  - 3-bit (log2 DATA_WIDTH) bit index.
- Frame length: Busy is high for exactly (1 + DATA_WIDTH + PAR_EN + 1) * P consecutive cycles.
- End of STOP:
  - After the final stop cycle, FSM returns to IDLE, TX_OUT=1 and Busy=0 in the same edge.
  - DATA_VALID=1 in that IDLE cycle is accepted, giving a 1-cycle minimum idle gap between frames.
- Simultaneous reset and DATA_VALID: reset wins.
- TX_OUT is driven from a flop only; no combinational glitches.

Optional Feature:
- Macro UART_TX_TWO_STOP_EN.
- When defined:
  - STOP lasts 2*P cycles (two stop bits).
  - Busy length is (DATA_WIDTH + PAR_EN + 3) * P.
- When undefined: one stop bit, as in Behaviour.

Test Plan:
- Even parity: Prescale=8, PAR_EN=1, PAR_TYP=0, P_DATA=0xA5.
  - TX_OUT bit sequence, each bit 8 cycles: 0, 1,0,1,0,0,1,0,1, parity 0, stop 1.
  - Busy high for 88 cycles, then TX_OUT=1, Busy=0.
- Odd parity: Prescale=16, PAR_EN=1, PAR_TYP=1, P_DATA=0x01.
  - Parity bit = 0.
  - Busy high for 176 cycles.
- No parity: Prescale=8, PAR_EN=0, P_DATA=0xFF.
  - Sequence 0, eight 1s, stop 1.
  - Busy high for 80 cycles.
- Busy handling: during Busy, pulse DATA_VALID with P_DATA=0x3C and change Prescale to 4.
  - Frame in flight is unchanged; no second frame follows.
  - DATA_VALID held high through frame end starts the next frame exactly 1 cycle after Busy falls.
- Reset mid-frame: assert RST=0 during data bit 3.
  - TX_OUT=1 and Busy=0 immediately (asynchronously).
  - After release the line stays idle until a new DATA_VALID.
- Prescale=0 with P_DATA=0x55, PAR_EN=0.
  - Treated as 1: 10-cycle frame 0,1,0,1,0,1,0,1,0,1.
  - With UART_TX_TWO_STOP_EN, an 11-cycle frame.
